display_scan_scheduler: RTL

- Controller for the 4-digit 7-segment display path: the digit counter, the digit-enable decode (s1..s4) and the bebida/sensor segment mux.
- Replaces the free-running 2-bit counter with a prescaled scan engine that inserts anti-ghosting blanking at each digit change.
- Schedules which source (drink info or sensor info) owns the display: periodic alternation plus a sticky sensor-alarm override.
- Source switches happen only at frame boundaries, so a scan frame never mixes the two sources.

---
 rtl/display_scan_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/display_scan_scheduler.sv
// Four-digit 7-segment scan controller: prescaled digit scan with anti-ghosting
// blanking, and frame-aligned scheduling of the drink/sensor/alarm display source.
module display_scan_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int ALT_FRAMES   = 200,
  parameter int ALARM_FRAMES = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       drink_valid,
  input  logic       sensor_alarm,
  output logic [1:0] digit_idx,
  output logic [3:0] an,
  output logic       blank,
  output logic       src_sel,
  output logic       frame_tick,
  output logic [1:0] state
);

  localparam int PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FMAX = (ALT_FRAMES > ALARM_FRAMES) ? ALT_FRAMES : ALARM_FRAMES;
  localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [FW-1:0] ALT_LAST   = FW'(ALT_FRAMES - 1);
  localparam logic [FW-1:0] ALARM_LAST = FW'(ALARM_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_DRINK  = 2'b01,
    ST_SENSOR = 2'b10,
    ST_ALARM  = 2'b11
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] pcnt_r;
  logic [1:0]    digit_idx_r;
  logic [FW-1:0] fcnt_r;
  logic          alarm_pend_r;
  logic          tick_s;
  logic          blank_s;

  assign tick_s  = (state_r != ST_OFF) && (pcnt_r == PCNT_LAST) && (digit_idx_r == 2'd3);
  assign blank_s = (state_r == ST_OFF) || (pcnt_r < BLANK_END);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: en=0 wins anywhere; source changes only on a frame boundary
  always_comb begin
    state_nxt_s = state_r;
    if (!en) begin
      state_nxt_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (drink_valid) begin
            state_nxt_s = ST_DRINK;
          end else begin
            state_nxt_s = ST_SENSOR;
          end
        end
        ST_DRINK: begin
          if (tick_s && alarm_pend_r) begin
            state_nxt_s = ST_ALARM;
          end else if (tick_s && (!drink_valid || (fcnt_r == ALT_LAST))) begin
            state_nxt_s = ST_SENSOR;
          end else begin
            state_nxt_s = ST_DRINK;
          end
        end
        ST_SENSOR: begin
          if (tick_s && alarm_pend_r) begin
            state_nxt_s = ST_ALARM;
          end else if (tick_s && (fcnt_r == ALT_LAST) && drink_valid) begin
            state_nxt_s = ST_DRINK;
          end else begin
            state_nxt_s = ST_SENSOR;
          end
        end
        ST_ALARM: begin
          if (tick_s && !sensor_alarm && (fcnt_r == ALARM_LAST)) begin
            state_nxt_s = drink_valid ? ST_DRINK : ST_SENSOR;
          end else begin
            state_nxt_s = ST_ALARM;
          end
        end
        default: begin
          state_nxt_s = ST_OFF;
        end
      endcase
    end
  end

  // Scan prescaler and digit index; held at zero while off or being switched off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r      <= '0;
      digit_idx_r <= 2'd0;
    end else if (!en || (state_r == ST_OFF)) begin
      pcnt_r      <= '0;
      digit_idx_r <= 2'd0;
    end else if (pcnt_r == PCNT_LAST) begin
      pcnt_r      <= '0;
      digit_idx_r <= digit_idx_r + 2'd1;
    end else begin
      pcnt_r      <= pcnt_r + PW'(1);
      digit_idx_r <= digit_idx_r;
    end
  end

  // Frame counter: restarts on every source change and while an alarm is still asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_r <= '0;
    end else if (state_nxt_s != state_r) begin
      fcnt_r <= '0;
    end else if ((state_r == ST_ALARM) && sensor_alarm) begin
      fcnt_r <= '0;
    end else if (tick_s && (state_r == ST_SENSOR) && (fcnt_r == ALT_LAST)) begin
      fcnt_r <= '0;
    end else if (tick_s) begin
      fcnt_r <= fcnt_r + FW'(1);
    end else begin
      fcnt_r <= fcnt_r;
    end
  end

  // Sticky alarm request, latched so short pulses survive until the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_pend_r <= 1'b0;
    end else if (!en || (state_r == ST_OFF)) begin
      alarm_pend_r <= 1'b0;
    end else if ((state_nxt_s == ST_ALARM) && (state_r != ST_ALARM)) begin
      alarm_pend_r <= 1'b0;
    end else if (sensor_alarm && ((state_r == ST_DRINK) || (state_r == ST_SENSOR))) begin
      alarm_pend_r <= 1'b1;
    end else begin
      alarm_pend_r <= alarm_pend_r;
    end
  end

  // Output decode straight from registers, no added latency
  always_comb begin
    an         = 4'b0000;
    blank      = blank_s;
    frame_tick = tick_s;
    digit_idx  = digit_idx_r;
    state      = state_r;
    src_sel    = 1'b0;
    if (blank_s) begin
      an = 4'b0000;
    end else begin
      an = 4'b0001 << digit_idx_r;
    end
    if ((state_r == ST_SENSOR) || (state_r == ST_ALARM)) begin
      src_sel = 1'b1;
    end else begin
      src_sel = 1'b0;
    end
  end

endmodule
